// File: rtl/dl_mem_pkg.sv
// rtl/dl_mem_pkg.sv - shared types and defaults for the download/CPU memory arbiter
package dl_mem_pkg;

   // Default memory byte-address width
   localparam int DEF_ADDR_W = 25;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DL_ISSUE  = 2'd1,
      CPU_ISSUE = 2'd2
   } arb_state_t;

   // One buffered download write at the default address width
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [7:0]            data;
   } dl_entry_t;

endpackage

// File: rtl/dl_wr_fifo.sv
// rtl/dl_wr_fifo.sv - synchronous download write buffer, drops pushes when full
module dl_wr_fifo
   import dl_mem_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = dl_entry_t
)
(
   input  logic   clk,
   input  logic   reset_n,
   input  logic   push,
   input  entry_t push_entry,
   input  logic   pop,
   output entry_t head,
   output logic   empty,
   output logic   dropped
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign dropped = push && full && !do_pop;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/dl_mem_arbiter.sv
// rtl/dl_mem_arbiter.sv - shares one byte memory port between download writes and CPU accesses
module dl_mem_arbiter
   import dl_mem_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DL_BURST_MAX = 8
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   input  logic              dl_active,
   output logic              dl_overflow,
   output logic              cpu_hold,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata
);

   localparam int BC_W = $clog2(DL_BURST_MAX + 1);

   // Entry sized to this instance's address width
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } entry_t;

   arb_state_t       state;
   logic [BC_W-1:0]  burst_cnt;
   entry_t           push_entry;
   entry_t           head;
   logic             fifo_empty;
   logic             fifo_dropped;
   logic             pop;
   logic             limit_hit;
   logic             dl_pending;
   logic             dl_active_q;

   assign push_entry.addr = dl_addr;
   assign push_entry.data = dl_data;

   dl_wr_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (dl_wr),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .empty      (fifo_empty),
      .dropped    (fifo_dropped)
   );

   assign cpu_hold   = dl_active || !fifo_empty;
   // The CPU has waited through the maximum download burst
   assign limit_hit  = cpu_req && (burst_cnt == BC_W'(DL_BURST_MAX));
   // A strobe arriving into an empty FIFO still outranks a waiting CPU request
   assign dl_pending = !fifo_empty || dl_wr;
   assign pop        = (state == IDLE) && !fifo_empty && !limit_hit;

   // Sticky overflow flag, re-armed at the start of each download
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_active_q <= 1'b0;
         dl_overflow <= 1'b0;
      end else begin
         dl_active_q <= dl_active;
         if (fifo_dropped)
            dl_overflow <= 1'b1;
         else if (dl_active && !dl_active_q)
            dl_overflow <= 1'b0;
      end
   end

   // Arbitration FSM; the burst counter only counts grants made while the CPU waits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         burst_cnt <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  mem_addr  <= head.addr;
                  mem_wdata <= head.data;
                  mem_we    <= 1'b1;
                  mem_req   <= 1'b1;
                  burst_cnt <= cpu_req ? burst_cnt + BC_W'(1) : '0;
                  state     <= DL_ISSUE;
               end else if (cpu_req && (limit_hit || !dl_pending)) begin
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  mem_we    <= cpu_we;
                  mem_req   <= 1'b1;
                  burst_cnt <= '0;
                  state     <= CPU_ISSUE;
               end else if (!cpu_req) begin
                  burst_cnt <= '0;
               end
            end
            DL_ISSUE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= IDLE;
               end
            end
            CPU_ISSUE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  cpu_ack <= 1'b1;
                  if (!mem_we) cpu_rdata <= mem_rdata;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// tb/tb_dl_mem_arbiter.sv - directed self-checking bench for dl_mem_arbiter
module tb_dl_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_active;
   logic        dl_overflow;
   logic        cpu_hold;
   logic        cpu_req;
   logic        cpu_we;
   logic [24:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [24:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   typedef struct {
      logic        we;
      logic [24:0] addr;
      logic [7:0]  data;
      logic        cpu_pend;
   } grant_t;

   grant_t glog[$];
   logic   req_prev;
   logic   cpu_req_prev;
   int     dl_issues;
   int     pushes;
   bit     auto_ack;
   logic [7:0] rd_value;
   int     checks;
   int     passed;

   dl_mem_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .dl_active   (dl_active),
      .dl_overflow (dl_overflow),
      .cpu_hold    (cpu_hold),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant log: records each new mem_req with the cpu_req level seen at the issuing edge
   always @(negedge clk) begin
      grant_t g;
      if (mem_req && !req_prev) begin
         g.we       = mem_we;
         g.addr     = mem_addr;
         g.data     = mem_wdata;
         g.cpu_pend = cpu_req_prev;
         glog.push_back(g);
         if (mem_we) dl_issues++;
      end
      req_prev     = mem_req;
      cpu_req_prev = cpu_req;
   end

   // Memory responder: acks every request one cycle after it appears
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (auto_ack) begin
            mem_ack   = mem_req && !mem_ack;
            mem_rdata = rd_value;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, want finished");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (!mem_req && !cpu_hold) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      step();
      checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
      checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); else passed++;
      checks++; if (dl_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", dl_overflow); else passed++;
      checks++; if (mem_addr !== 25'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
      checks++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else passed++;
      checks++; if (cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); else passed++;
      checks++; if (cpu_hold !== 1'b0) $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); else passed++;
   endtask

   task automatic test_single_dl();
      auto_ack = 1'b0;
      mem_ack  = 1'b0;
      dl_wr    = 1'b1;
      dl_addr  = 25'h000100;
      dl_data  = 8'hC3;
      step();
      dl_wr = 1'b0;
      checks++; if (mem_req !== 1'b0) $display("FAIL single_e0_req: got %b want 0", mem_req); else passed++;
      checks++; if (cpu_hold !== 1'b1) $display("FAIL single_e0_hold: got %b want 1", cpu_hold); else passed++;
      step();
      checks++; if (mem_req !== 1'b1) $display("FAIL single_e1_req: got %b want 1", mem_req); else passed++;
      checks++; if (mem_we !== 1'b1) $display("FAIL single_e1_we: got %b want 1", mem_we); else passed++;
      checks++; if (mem_addr !== 25'h000100) $display("FAIL single_e1_addr: got %h want 000100", mem_addr); else passed++;
      checks++; if (mem_wdata !== 8'hC3) $display("FAIL single_e1_data: got %h want c3", mem_wdata); else passed++;
      step();
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h000100 || mem_wdata !== 8'hC3)
         $display("FAIL single_hold: got req=%b addr=%h data=%h want 1/000100/c3", mem_req, mem_addr, mem_wdata);
      else passed++;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0) $display("FAIL single_ack_req: got %b want 0", mem_req); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL single_ack_we: got %b want 0", mem_we); else passed++;
   endtask

   task automatic test_overflow();
      bit ok;
      auto_ack  = 1'b0;
      mem_ack   = 1'b0;
      dl_active = 1'b1;
      step();
      glog.delete();
      for (int i = 0; i < 6; i++) begin
         dl_wr   = 1'b1;
         dl_addr = 25'(32'h200 + i);
         dl_data = 8'(32'h10 + i);
         step();
         if (i == 4) begin
            checks++; if (dl_overflow !== 1'b0) $display("FAIL ovf_before_drop: got %b want 0", dl_overflow); else passed++;
         end
      end
      dl_wr = 1'b0;
      checks++; if (dl_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", dl_overflow); else passed++;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h000200)
         $display("FAIL ovf_first_issue: got req=%b addr=%h want 1/000200", mem_req, mem_addr);
      else passed++;
      dl_active = 1'b0;
      step();
      step();
      checks++; if (dl_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", dl_overflow); else passed++;
      dl_active = 1'b1;
      step();
      checks++; if (dl_overflow !== 1'b0) $display("FAIL ovf_clear_on_rise: got %b want 0", dl_overflow); else passed++;
      dl_active = 1'b0;
      auto_ack  = 1'b1;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL ovf_drain: got busy want idle"); else passed++;
      checks++; if (glog.size() != 5) $display("FAIL ovf_grant_count: got %0d want 5", glog.size()); else passed++;
      for (int k = 0; k < 5 && k < glog.size(); k++) begin
         checks++; if (glog[k].addr !== 25'(32'h200 + k) || glog[k].data !== 8'(32'h10 + k) || glog[k].we !== 1'b1)
            $display("FAIL ovf_entry%0d: got addr=%h data=%h we=%b want %h/%h/1", k, glog[k].addr, glog[k].data,
                     glog[k].we, 25'(32'h200 + k), 8'(32'h10 + k));
         else passed++;
      end
   endtask

   task automatic test_cpu_read();
      auto_ack  = 1'b1;
      rd_value  = 8'h5A;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 25'h010000;
      cpu_wdata = 8'hEE;
      step();
      checks++; if (mem_req !== 1'b1) $display("FAIL rd_issue_req: got %b want 1", mem_req); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL rd_issue_we: got %b want 0", mem_we); else passed++;
      checks++; if (mem_addr !== 25'h010000) $display("FAIL rd_issue_addr: got %h want 010000", mem_addr); else passed++;
      checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", cpu_ack); else passed++;
      step();
      checks++; if (cpu_ack !== 1'b1) $display("FAIL rd_ack: got %b want 1", cpu_ack); else passed++;
      checks++; if (cpu_rdata !== 8'h5A) $display("FAIL rd_data: got %h want 5a", cpu_rdata); else passed++;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL rd_release: got req=%b we=%b want 0/0", mem_req, mem_we);
      else passed++;
      cpu_req  = 1'b0;
      rd_value = 8'h00;
      step();
      checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_pulse: got %b want 0", cpu_ack); else passed++;
      checks++; if (cpu_rdata !== 8'h5A) $display("FAIL rd_data_held: got %h want 5a", cpu_rdata); else passed++;
      auto_ack = 1'b0;
      mem_ack  = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
      checks++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0)
         $display("FAIL stray_ack: got req=%b ack=%b want 0/0", mem_req, cpu_ack);
      else passed++;
   endtask

   task automatic test_starvation();
      int acks;
      int n1;
      int n2;
      int seg;
      int ndl;
      bit ok;
      auto_ack  = 1'b1;
      rd_value  = 8'hA5;
      glog.delete();
      dl_issues = 0;
      pushes    = 0;
      acks      = 0;
      cpu_we    = 1'b0;
      cpu_addr  = 25'h040000;
      for (int cyc = 0; cyc < 300 && acks < 2; cyc++) begin
         dl_wr = ((pushes - dl_issues) < 3) && (acks < 2);
         if (dl_wr) begin
            dl_addr = 25'(32'h300 + pushes);
            dl_data = 8'(pushes);
            pushes++;
         end
         if (cyc == 8) cpu_req = 1'b1;
         step();
         if (cpu_ack) begin
            acks++;
            if (acks == 2) cpu_req = 1'b0;
         end
      end
      dl_wr   = 1'b0;
      cpu_req = 1'b0;
      checks++; if (acks != 2) $display("FAIL starve_cpu_acks: got %0d want 2", acks); else passed++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL starve_drain: got busy want idle"); else passed++;
      n1 = 0; n2 = 0; seg = 0; ndl = 0;
      foreach (glog[k]) begin
         if (!glog[k].we) seg++;
         else begin
            ndl++;
            if (glog[k].cpu_pend && seg == 0) n1++;
            else if (glog[k].cpu_pend && seg == 1) n2++;
         end
      end
      checks++; if (n1 != 8) $display("FAIL starve_round1: got %0d dl grants want 8", n1); else passed++;
      checks++; if (n2 != 8) $display("FAIL starve_round2: got %0d dl grants want 8", n2); else passed++;
      checks++; if (ndl != pushes) $display("FAIL starve_all_written: got %0d want %0d", ndl, pushes); else passed++;
      checks++; if (dl_overflow !== 1'b0) $display("FAIL starve_overflow: got %b want 0", dl_overflow); else passed++;
   endtask

   task automatic test_back_to_back();
      auto_ack  = 1'b1;
      dl_wr     = 1'b1;
      dl_addr   = 25'h002000;
      dl_data   = 8'h77;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 25'h003000;
      cpu_wdata = 8'h99;
      step();
      dl_wr = 1'b0;
      checks++; if (mem_req !== 1'b0) $display("FAIL sim_e0_req: got %b want 0", mem_req); else passed++;
      checks++; if (cpu_hold !== 1'b1) $display("FAIL sim_e0_hold: got %b want 1", cpu_hold); else passed++;
      step();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h002000 || mem_wdata !== 8'h77)
         $display("FAIL sim_dl_first: got req=%b we=%b addr=%h data=%h want 1/1/002000/77", mem_req, mem_we, mem_addr, mem_wdata);
      else passed++;
      step();
      checks++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0)
         $display("FAIL sim_gap: got req=%b ack=%b want 0/0", mem_req, cpu_ack);
      else passed++;
      step();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h003000 || mem_wdata !== 8'h99)
         $display("FAIL sim_cpu_second: got req=%b we=%b addr=%h data=%h want 1/1/003000/99", mem_req, mem_we, mem_addr, mem_wdata);
      else passed++;
      step();
      checks++; if (cpu_ack !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL sim_cpu_ack: got ack=%b req=%b want 1/0", cpu_ack, mem_req);
      else passed++;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      step();
      checks++; if (cpu_ack !== 1'b0) $display("FAIL sim_ack_pulse: got %b want 0", cpu_ack); else passed++;
   endtask

   task automatic test_mid_reset();
      bit ok;
      auto_ack  = 1'b0;
      mem_ack   = 1'b0;
      dl_active = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         dl_wr   = 1'b1;
         dl_addr = 25'(32'h500 + i);
         dl_data = 8'(32'h50 + i);
         step();
      end
      dl_wr = 1'b0;
      checks++; if (mem_req !== 1'b1 || dl_overflow !== 1'b1)
         $display("FAIL mrst_pre: got req=%b ovf=%b want 1/1", mem_req, dl_overflow);
      else passed++;
      dl_active = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) $display("FAIL mrst_req: got %b want 0", mem_req); else passed++;
      checks++; if (dl_overflow !== 1'b0) $display("FAIL mrst_ovf: got %b want 0", dl_overflow); else passed++;
      checks++; if (cpu_hold !== 1'b0) $display("FAIL mrst_fifo_empty: got hold=%b want 0", cpu_hold); else passed++;
      checks++; if (mem_addr !== 25'h0) $display("FAIL mrst_addr: got %h want 0", mem_addr); else passed++;
      step();
      step();
      reset_n = 1'b1;
      step();
      glog.delete();
      auto_ack = 1'b1;
      dl_wr    = 1'b1;
      dl_addr  = 25'h000600;
      dl_data  = 8'h3C;
      step();
      dl_wr = 1'b0;
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h000600 || mem_wdata !== 8'h3C)
         $display("FAIL mrst_after: got req=%b addr=%h data=%h want 1/000600/3c", mem_req, mem_addr, mem_wdata);
      else passed++;
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL mrst_drain: got busy want idle"); else passed++;
      checks++; if (glog.size() != 1) $display("FAIL mrst_grants: got %0d want 1", glog.size()); else passed++;
   endtask

   initial begin
      checks       = 0;
      passed       = 0;
      auto_ack     = 1'b0;
      rd_value     = 8'h00;
      req_prev     = 1'b0;
      cpu_req_prev = 1'b0;
      dl_issues    = 0;
      pushes       = 0;
      reset_n      = 1'b0;
      dl_wr        = 1'b0;
      dl_addr      = '0;
      dl_data      = '0;
      dl_active    = 1'b0;
      cpu_req      = 1'b0;
      cpu_we       = 1'b0;
      cpu_addr     = '0;
      cpu_wdata    = '0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      step();
      step();
      step();
      reset_n = 1'b1;
      test_reset();
      test_single_dl();
      test_overflow();
      test_cpu_read();
      test_starvation();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
